hdmi_i2c_target: RTL and testbench
==================================

// Module: hdmi_i2c_target
// PURPOSE
// I2C target (responder) for the HDMI transmitter configuration bus; it answers the I2C
// master that programs the HDMI PHY. Holds a byte-wide register file with an 8-bit
// auto-incrementing sub-address pointer, and supports writes and reads (repeated START).
// Used as the bring-up stand-in for the transmitter and as the bus model in master benches.
// PARAMETERS
// DEV_ADDR   7'h39  7-bit target address (8'h72 write / 8'h73 read)
// RESET_VAL  8'h00  reset value of every register-file entry
// PORTS
// clk        in   1  system clock, >= 8x SCL rate
// resetn     in   1  asynchronous active-low reset
// scl        in   1  observed SCL line level
// sda_in     in   1  observed SDA line level
// sda_out    out  1  SDA drive: 1 = release (open-drain high), 0 = pull low
// reg_raddr  in   8  host-side register read address
// reg_rdata  out  8  regfile[reg_raddr], registered, 1-cycle latency
// wr_strobe  out  1  1-cycle pulse per accepted write data byte
// wr_addr    out  8  register address of the last accepted write
// wr_data    out  8  data of the last accepted write
// busy       out  1  1 from address match until STOP/START/NACK end
// BEHAVIOUR
// - Reset (async, immediate): sda_out=1, wr_strobe=0, wr_addr=0, wr_data=0, busy=0,
//   reg_rdata=RESET_VAL, pointer=0, all regs=RESET_VAL, state=IDLE.
// - scl and sda_in each pass through a 2-FF synchronizer; edge detect is on synced values.
//   Internal event latency is 3 clk after a pin change.
// - START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both are
//   detected in every state.
// - Bits are sampled on SCL rising edges. sda_out changes only on the clk after an SCL
//   falling edge is detected, never while SCL is high.
// - States: IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT.
//   - IDLE --START--> ADDR. ADDR shifts in 8 bits, MSB first.
//   - ADDR: if addr[7:1]==DEV_ADDR, drive ACK (0) for one SCL pulse and set busy.
//     R/W=0 -> SUB. R/W=1 -> load regfile[pointer], then RDATA.
//   - ADDR mismatch: release SDA, go to WAIT. WAIT ignores everything except START/STOP.
//   - SUB: 8 bits -> pointer; ACK; then WDATA.
//   - WDATA: 8 bits -> ACK, regfile[pointer]<=byte, wr_strobe pulse with
//     wr_addr=pointer and wr_data=byte, pointer+1. Returns to WDATA.
//     The write commits on the clk after the 8th SCL rise.
//   - RDATA: shift the byte out MSB first. After bit 0's SCL fall, release SDA and
//     pointer+1. RACK samples the master bit on SCL rise: 0 -> load next byte, RDATA;
//     1 (NACK) -> WAIT.
// - Pointer wraps 8'hFF -> 8'h00 for both reads and writes.
// - The pointer persists across START/STOP and is cleared only by reset.
// - STOP anywhere -> IDLE, sda_out=1, busy=0. A partial byte is discarded (no strobe).
// - START anywhere (repeated START) -> ADDR, sda_out=1. The pointer is kept.
// - Host read of an address written in the same clk returns the old value.
// - Reset mid-transfer releases SDA asynchronously. The next access needs a fresh START.
// TESTING
// - START, 8'h72 (ACK), 8'h41 (ACK), 8'h10 (ACK), STOP -> three ACK low pulses;
//   wr_strobe once with wr_addr=8'h41, wr_data=8'h10; reg_raddr=8'h41 gives 8'h10;
//   busy=0 after STOP.
// - Burst: START, 8'h72, 8'hFE, then 8'hA1, 8'hA2, 8'hA3 -> regs FE=A1, FF=A2, 00=A3;
//   three strobes; pointer wraps to 8'h01.
// - Read: write sub 8'h41, Sr, 8'h73 (ACK), SDA shows 8'h10 MSB first; master ACK ->
//   8'h00 from 0x42; master NACK -> sda_out stays 1; then STOP.
// - Wrong address 8'h4C then 8'h41, 8'h55 -> sda_out stays 1 throughout, no strobe,
//   busy stays 0, reg 0x41 unchanged.
// - STOP after 5 bits of a data byte -> no strobe, regs unchanged, state IDLE;
//   a following valid write succeeds.
// - resetn=0 while driving a read 0 bit -> sda_out=1 within the same clk; regs=RESET_VAL;
//   no ACK until a new START.

Source files
------------

// File: rtl/hdmi_i2c_target.sv
// I2C target for the HDMI TX configuration bus: byte register file behind an 8-bit
// auto-incrementing sub-address. Pin-to-action latency 3 clk; SDA moves only after an SCL fall.
module hdmi_i2c_target #(
    parameter logic [6:0] DEV_ADDR  = 7'h39,
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       scl,
    input  logic       sda_in,
    output logic       sda_out,
    input  logic [7:0] reg_raddr,
    output logic [7:0] reg_rdata,
    output logic       wr_strobe,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT
    } state_t;

    state_t     state;
    logic       scl_s1, scl_s2, scl_d;
    logic       sda_s1, sda_s2, sda_d;
    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [3:0] bit_cnt;
    logic [6:0] rx_sh;
    logic [7:0] rx_byte, tx_sh, pointer;
    logic       rw, ack_ph;
    logic [7:0] regs [256];

    // Synchronizers reset to the idle bus level so reset release never fakes a START.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_d  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_s1 <= scl;
            scl_s2 <= scl_s1;
            scl_d  <= scl_s2;
            sda_s1 <= sda_in;
            sda_s2 <= sda_s1;
            sda_d  <= sda_s2;
        end
    end

    assign scl_rise  = scl_s2 & ~scl_d;
    assign scl_fall  = ~scl_s2 & scl_d;
    assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
    assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;
    assign rx_byte   = {rx_sh, sda_s2};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            sda_out   <= 1'b1;
            busy      <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            reg_rdata <= RESET_VAL;
            pointer   <= '0;
            bit_cnt   <= '0;
            rx_sh     <= '0;
            tx_sh     <= '0;
            rw        <= 1'b0;
            ack_ph    <= 1'b0;
            regs      <= '{default: RESET_VAL};
        end else begin
            wr_strobe <= 1'b0;
            reg_rdata <= regs[reg_raddr];
            if (start_det) begin
                state   <= ADDR;
                bit_cnt <= '0;
                sda_out <= 1'b1;
                busy    <= 1'b0;
                ack_ph  <= 1'b0;
            end else if (stop_det) begin
                state   <= IDLE;
                sda_out <= 1'b1;
                busy    <= 1'b0;
                ack_ph  <= 1'b0;
            end else begin
                case (state)
                    ADDR: if (scl_rise) begin
                        rx_sh   <= rx_byte[6:0];
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt <= '0;
                            ack_ph  <= 1'b0;
                            if (rx_byte[7:1] == DEV_ADDR) begin
                                busy  <= 1'b1;
                                rw    <= rx_byte[0];
                                tx_sh <= regs[pointer];
                                state <= ADDR_ACK;
                            end else begin
                                state <= WAIT;
                            end
                        end
                    end
                    SUB: if (scl_rise) begin
                        rx_sh   <= rx_byte[6:0];
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt <= '0;
                            ack_ph  <= 1'b0;
                            pointer <= rx_byte;
                            state   <= SUB_ACK;
                        end
                    end
                    WDATA: if (scl_rise) begin
                        rx_sh   <= rx_byte[6:0];
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt       <= '0;
                            ack_ph        <= 1'b0;
                            regs[pointer] <= rx_byte;
                            wr_strobe     <= 1'b1;
                            wr_addr       <= pointer;
                            wr_data       <= rx_byte;
                            pointer       <= pointer + 8'd1;
                            state         <= WDATA_ACK;
                        end
                    end
                    // First SCL fall drives ACK, second fall ends the ACK clock.
                    ADDR_ACK, SUB_ACK, WDATA_ACK: if (scl_fall) begin
                        if (!ack_ph) begin
                            sda_out <= 1'b0;
                            ack_ph  <= 1'b1;
                        end else begin
                            ack_ph  <= 1'b0;
                            bit_cnt <= '0;
                            if (state == ADDR_ACK && rw) begin
                                sda_out <= tx_sh[7];
                                tx_sh   <= {tx_sh[6:0], 1'b0};
                                state   <= RDATA;
                            end else begin
                                sda_out <= 1'b1;
                                state   <= (state == ADDR_ACK) ? SUB : WDATA;
                            end
                        end
                    end
                    RDATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                        if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_out <= 1'b1;
                                pointer <= pointer + 8'd1;
                                ack_ph  <= 1'b0;
                                state   <= RACK;
                            end else begin
                                sda_out <= tx_sh[7];
                                tx_sh   <= {tx_sh[6:0], 1'b0};
                            end
                        end
                    end
                    RACK: begin
                        if (scl_rise) begin
                            if (sda_s2) begin
                                busy  <= 1'b0;
                                state <= WAIT;
                            end else begin
                                tx_sh  <= regs[pointer];
                                ack_ph <= 1'b1;
                            end
                        end else if (scl_fall && ack_ph) begin
                            sda_out <= tx_sh[7];
                            tx_sh   <= {tx_sh[6:0], 1'b0};
                            bit_cnt <= '0;
                            ack_ph  <= 1'b0;
                            state   <= RDATA;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_hdmi_i2c_target.sv
// Bench for hdmi_i2c_target: bit-banged I2C master on a wired-AND SDA with a write/read scoreboard.
`timescale 1ns/1ps
module tb_hdmi_i2c_target;
    localparam int Q = 50;

    logic       clk = 1'b0;
    logic       resetn, scl, sda_m, sda_in, sda_out;
    logic [7:0] reg_raddr, reg_rdata, wr_addr, wr_data;
    logic       wr_strobe, busy;

    int         checks = 0;
    int         errors = 0;
    int         low_cnt = 0;
    int         busy_cnt = 0;
    logic       sda_prev = 1'b1;
    logic [7:0] mdl [256];
    logic [7:0] mptr = 8'h00;
    logic [15:0] wq [$];
    logic [7:0] rq [$];

    assign sda_in = sda_m & sda_out;

    hdmi_i2c_target #(.DEV_ADDR(7'h39), .RESET_VAL(8'h00)) dut (
        .clk(clk), .resetn(resetn), .scl(scl), .sda_in(sda_in), .sda_out(sda_out),
        .reg_raddr(reg_raddr), .reg_rdata(reg_rdata), .wr_strobe(wr_strobe),
        .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        logic [15:0] e_wr;
        if (sda_out === 1'b0) low_cnt++;
        if (busy === 1'b1) busy_cnt++;
        if (resetn === 1'b1 && sda_out !== sda_prev) begin
            checks++;
            if (scl !== 1'b0) begin
                errors++;
                $display("FAIL sda_while_scl_high: sda_out became %b with scl=%b, required scl=0", sda_out, scl);
            end
        end
        sda_prev = sda_out;
        if (resetn === 1'b1 && wr_strobe === 1'b1) begin
            checks++;
            if (wq.size() == 0) begin
                errors++;
                $display("FAIL strobe_unexpected: got addr=%h data=%h, required no strobe", wr_addr, wr_data);
            end else begin
                e_wr = wq.pop_front();
                if ({wr_addr, wr_data} !== e_wr) begin
                    errors++;
                    $display("FAIL strobe_value: got addr=%h data=%h, required addr=%h data=%h",
                             wr_addr, wr_data, e_wr[15:8], e_wr[7:0]);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run exceeded 1 ms, required completion");
        $fatal(1, "timeout");
    end

    task automatic i2c_bit(input logic b, output logic r);
        sda_m = b; #Q;
        scl = 1'b1; #Q;
        r = sda_in; #Q;
        scl = 1'b0; #Q;
    endtask

    task automatic i2c_start;
        sda_m = 1'b1; #Q;
        scl = 1'b1; #Q;
        sda_m = 1'b0; #Q;
        scl = 1'b0; #Q;
    endtask

    task automatic i2c_stop;
        sda_m = 1'b0; #Q;
        scl = 1'b1; #Q;
        sda_m = 1'b1; #Q;
    endtask

    task automatic i2c_wbyte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) i2c_bit(b[i], r);
        i2c_bit(1'b1, ack);
    endtask

    task automatic i2c_rbyte(input logic mack, output logic [7:0] d, output logic r);
        for (int i = 7; i >= 0; i--) i2c_bit(1'b1, d[i]);
        i2c_bit(mack, r);
    endtask

    task automatic send_data(input logic [7:0] d, output logic ack);
        wq.push_back({mptr, d});
        mdl[mptr] = d;
        mptr = mptr + 8'd1;
        i2c_wbyte(d, ack);
    endtask

    task automatic host_read(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        reg_raddr = a;
        @(posedge clk);
        #1 d = reg_rdata;
    endtask

    task automatic test_reset;
        logic [7:0] d;
        resetn = 1'b0; scl = 1'b1; sda_m = 1'b1; reg_raddr = 8'h41;
        #23;
        checks++;
        if ({sda_out, busy, wr_strobe, wr_addr, wr_data, reg_rdata} !== {1'b1, 1'b0, 1'b0, 24'h0}) begin
            errors++;
            $display("FAIL reset_outputs: got sda=%b busy=%b strb=%b wa=%h wd=%h rd=%h, required 1 0 0 00 00 00",
                     sda_out, busy, wr_strobe, wr_addr, wr_data, reg_rdata);
        end
        resetn = 1'b1;
        #Q;
        host_read(8'hC3, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL reset_reg: got %h, required 00", d); end
    endtask

    task automatic test_single_write;
        logic a0, a1, a2;
        logic [7:0] d;
        i2c_start;
        i2c_wbyte(8'h72, a0);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_on_match: got %b, required 1", busy); end
        i2c_wbyte(8'h41, a1);
        mptr = 8'h41;
        send_data(8'h10, a2);
        i2c_stop;
        checks++;
        if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL write_acks: got %b, required 000", {a0, a1, a2}); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_stop: got %b, required 0", busy); end
        host_read(8'h41, d);
        checks++;
        if (d !== 8'h10) begin errors++; $display("FAIL reg41: got %h, required 10", d); end
        checks++;
        if (wq.size() != 0) begin errors++; $display("FAIL strobe_missing: got %0d pending, required 0", wq.size()); end
    endtask

    task automatic test_burst;
        logic a, r;
        logic [7:0] d;
        i2c_start; i2c_wbyte(8'h72, a); i2c_wbyte(8'h01, a); mptr = 8'h01;
        send_data(8'h3C, a);
        i2c_stop;
        i2c_start; i2c_wbyte(8'h72, a); i2c_wbyte(8'hFE, a); mptr = 8'hFE;
        foreach (mdl[k]) if (k < 3) begin
            send_data(8'hA1 + 8'(k), a);
            checks++;
            if (a !== 1'b0) begin errors++; $display("FAIL burst_ack%0d: got %b, required 0", k, a); end
        end
        i2c_stop;
        host_read(8'hFE, d);
        checks++;
        if (d !== 8'hA1) begin errors++; $display("FAIL burst_fe: got %h, required a1", d); end
        host_read(8'hFF, d);
        checks++;
        if (d !== 8'hA2) begin errors++; $display("FAIL burst_ff: got %h, required a2", d); end
        host_read(8'h00, d);
        checks++;
        if (d !== 8'hA3) begin errors++; $display("FAIL burst_00: got %h, required a3", d); end
        // Pointer must now sit on 0x01, which holds 0x3C.
        i2c_start; i2c_wbyte(8'h73, a);
        rq.push_back(8'h3C); mptr = mptr + 8'd1;
        i2c_rbyte(1'b1, d, r);
        i2c_stop;
        checks++;
        if (d !== rq.pop_front()) begin errors++; $display("FAIL burst_wrap_read: got %h, required 3c", d); end
        checks++;
        if (wq.size() != 0) begin errors++; $display("FAIL burst_strobes: got %0d pending, required 0", wq.size()); end
    endtask

    task automatic test_read;
        logic a, r;
        logic [7:0] d;
        int l0;
        i2c_start; i2c_wbyte(8'h72, a); i2c_wbyte(8'h41, a); mptr = 8'h41;
        i2c_start; i2c_wbyte(8'h73, a);
        checks++;
        if (a !== 1'b0) begin errors++; $display("FAIL read_addr_ack: got %b, required 0", a); end
        rq.push_back(mdl[mptr]); mptr = mptr + 8'd1;
        i2c_rbyte(1'b0, d, r);
        checks++;
        if (d !== rq.pop_front()) begin errors++; $display("FAIL read_byte0: got %h, required 10", d); end
        rq.push_back(mdl[mptr]); mptr = mptr + 8'd1;
        l0 = low_cnt;
        i2c_rbyte(1'b1, d, r);
        checks++;
        if (d !== rq.pop_front()) begin errors++; $display("FAIL read_byte1: got %h, required 00", d); end
        checks++;
        if (r !== 1'b1) begin errors++; $display("FAIL read_nack_bit: got %b, required 1", r); end
        l0 = low_cnt;
        #(4 * Q);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_nack: got %b, required 0", busy); end
        i2c_stop;
        checks++;
        if (low_cnt != l0) begin errors++; $display("FAIL sda_after_nack: got %0d low samples, required 0", low_cnt - l0); end
    endtask

    task automatic test_wrong_addr;
        logic a0, a1, a2;
        logic [7:0] d;
        int l0, b0;
        l0 = low_cnt; b0 = busy_cnt;
        i2c_start; i2c_wbyte(8'h4C, a0); i2c_wbyte(8'h41, a1); i2c_wbyte(8'h55, a2); i2c_stop;
        checks++;
        if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL wrong_addr_acks: got %b, required 111", {a0, a1, a2}); end
        checks++;
        if (low_cnt != l0 || busy_cnt != b0) begin
            errors++;
            $display("FAIL wrong_addr_quiet: got %0d sda-low %0d busy samples, required 0 0", low_cnt - l0, busy_cnt - b0);
        end
        host_read(8'h41, d);
        checks++;
        if (d !== mdl[8'h41]) begin errors++; $display("FAIL wrong_addr_reg41: got %h, required %h", d, mdl[8'h41]); end
    endtask

    task automatic test_partial_stop;
        logic a, r;
        logic [7:0] d;
        i2c_start; i2c_wbyte(8'h72, a); i2c_wbyte(8'h50, a); mptr = 8'h50;
        for (int i = 0; i < 5; i++) i2c_bit(i[0], r);
        i2c_stop;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL partial_busy: got %b, required 0", busy); end
        host_read(8'h50, d);
        checks++;
        if (d !== mdl[8'h50]) begin errors++; $display("FAIL partial_reg50: got %h, required %h", d, mdl[8'h50]); end
        i2c_start; i2c_wbyte(8'h72, a); i2c_wbyte(8'h50, a); mptr = 8'h50;
        send_data(8'h5A, a);
        i2c_stop;
        checks++;
        if (a !== 1'b0) begin errors++; $display("FAIL partial_next_ack: got %b, required 0", a); end
        host_read(8'h50, d);
        checks++;
        if (d !== 8'h5A) begin errors++; $display("FAIL partial_next_reg: got %h, required 5a", d); end
        checks++;
        if (wq.size() != 0) begin errors++; $display("FAIL partial_strobes: got %0d pending, required 0", wq.size()); end
    endtask

    task automatic test_reset_mid_read;
        logic a;
        logic [7:0] d;
        i2c_start; i2c_wbyte(8'h72, a); i2c_wbyte(8'h41, a);
        i2c_start; i2c_wbyte(8'h73, a);
        checks++;
        if (sda_out !== 1'b0) begin errors++; $display("FAIL mid_read_drive: got %b, required 0", sda_out); end
        resetn = 1'b0;
        #1;
        checks++;
        if (sda_out !== 1'b1) begin errors++; $display("FAIL reset_release_sda: got %b, required 1", sda_out); end
        #20;
        resetn = 1'b1;
        for (int i = 0; i < 256; i++) mdl[i] = 8'h00;
        mptr = 8'h00;
        host_read(8'h41, d);
        checks++;
        if (d !== mdl[8'h41]) begin errors++; $display("FAIL reset_reg41: got %h, required 00", d); end
        i2c_wbyte(8'h72, a);
        checks++;
        if (a !== 1'b1) begin errors++; $display("FAIL ack_without_start: got %b, required 1", a); end
        i2c_stop;
        i2c_start; i2c_wbyte(8'h72, a); i2c_stop;
        checks++;
        if (a !== 1'b0) begin errors++; $display("FAIL ack_after_start: got %b, required 0", a); end
        checks++;
        if (wq.size() != 0) begin errors++; $display("FAIL final_strobes: got %0d pending, required 0", wq.size()); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mdl[i] = 8'h00;
        test_reset;
        test_single_write;
        test_burst;
        test_read;
        test_wrong_addr;
        test_partial_stop;
        test_reset_mid_read;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
